mem_stage: RTL and testbench
============================

# mem_stage

Memory-access pipeline stage between the EX/MEM register and the write-back stage. It issues loads and stores to the data memory over a req/gnt/rvalid handshake, aligns store data and byte enables, and right-justifies load data so the write-back sign/trim logic sees the addressed byte/half in bits [15:0]/[7:0]. It owns the MEM/WB pipeline register and stalls upstream stages while an access is outstanding.

## Interface
Parameters:
- none

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- ex_mem_reg_valid  in  1  instruction present in EX/MEM
- ex_mem_reg_alu_result  in  32  ALU result / memory address
- ex_mem_reg_rs2_data  in  32  store data
- ex_mem_reg_rd_adr  in  5  destination register
- ex_mem_reg_mem_ctrl_MemRead / _MemWrite  in  1 each  access type (never both)
- ex_mem_reg_wb_ctrl_RegWrite / _MemtoReg / _MemSign  in  1 each  forwarded WB controls
- ex_mem_reg_wb_ctrl_MemTrim  in  2  00 word, 01 half, 10 byte, 11 treated as word
- dmem_req  out  1  access request
- dmem_we  out  1  1 = store
- dmem_addr  out  32  word-aligned address ({alu_result[31:2],2'b00})
- dmem_be  out  4  byte enables
- dmem_wdata  out  32  lane-replicated store data
- dmem_gnt  in  1  request accepted this cycle
- dmem_rvalid  in  1  response (loads and stores) valid this cycle
- dmem_rdata  in  32  load data
- mem_stage_stall  out  1  hold EX/MEM and earlier stages
- mem_stage_misalign  out  1  one-cycle pulse, misaligned access dropped
- mem_wb_reg_alu_result, mem_wb_reg_data_mem_out  out  32 each  registered
- mem_wb_reg_rd_adr  out  5  registered
- mem_wb_reg_wb_ctrl_RegWrite / _MemtoReg / _MemSign  out  1 each  registered
- mem_wb_reg_wb_ctrl_MemTrim  out  2  registered

## Operation
- FSM states: IDLE, WAIT_GNT, WAIT_RSP. Reset -> IDLE.
- Mem op = valid & (MemRead|MemWrite) & aligned. Misaligned: half with addr[0]=1, word with addr[1:0]!=0; no request, misalign pulse, instruction retires as bubble (RegWrite=0).
- IDLE: mem op -> dmem_req=1 combinationally; gnt -> WAIT_RSP, else WAIT_GNT. Non-mem valid instruction passes straight to MEM/WB.
- WAIT_GNT: dmem_req held with stable addr/be/wdata/we; gnt -> WAIT_RSP.
- WAIT_RSP: dmem_req=0; rvalid -> MEM/WB loads instruction, IDLE. rvalid in IDLE/WAIT_GNT ignored.
- mem_stage_stall = mem op in IDLE/WAIT_GNT, or WAIT_RSP without rvalid. Upstream holds inputs stable while stall=1.
- Each stall cycle MEM/WB loads a bubble (RegWrite=0, MemtoReg=0, others 0): every instruction reaches WB exactly once.
- Byte enables: byte 4'b0001<<addr[1:0]; half 4'b0011<<{addr[1],1'b0}; word 4'b1111.
- Store data: byte {4{rs2[7:0]}}, half {2{rs2[15:0]}}, word rs2.
- Load data: mem_wb_reg_data_mem_out = dmem_rdata >> {addr[1:0],3'b000}; zero otherwise.

## Timing
- Reset: all outputs 0, dmem_req deasserts immediately on rst (async), FSM IDLE; response arriving after reset is ignored.
- Non-mem instruction: 1 cycle to MEM/WB, no stall.
- Access with gnt same cycle, rvalid next: 2 cycles, stall high 1 cycle. Each extra gnt/rvalid wait cycle adds 1.
- gnt and rvalid for the same access never in the same cycle; next access may issue in the cycle after rvalid.
- Misaligned: 1 cycle, misalign pulse aligned with bubble load.

## Structure
- Package mem_pkg: MemTrim encodings (TRIM_WORD/HALF/BYTE), FSM state enum.
- Sub-module store_align: combinational addr[1:0]+MemTrim+rs2 -> dmem_be, dmem_wdata, misaligned flag.

## Test plan
- Word load addr 0x100, gnt immediate, rvalid next, rdata 0xDEADBEEF -> stall 1 cycle, data_mem_out 0xDEADBEEF, RegWrite=1 once.
- Byte store addr 0x103, rs2 0x000000A5 -> be 4'b1000, wdata 0xA5A5A5A5, dmem_addr 0x100, we=1.
- Half load addr 0x202, rdata 0x8001_1234, gnt delayed 2 cycles -> req held 3 cycles, stall 4 cycles, data_mem_out 0x00008001, 4 bubbles then instruction.
- Word load addr 0x101 -> no dmem_req, misalign=1 one cycle, RegWrite=0 at MEM/WB.
- Reset asserted in WAIT_RSP, rvalid arrives after release -> outputs 0, req 0, rvalid ignored, next ALU op passes in 1 cycle.

Source files
------------

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared encodings for the memory-access stage
package mem_pkg;

    localparam logic [1:0] TRIM_WORD = 2'b00;
    localparam logic [1:0] TRIM_HALF = 2'b01;
    localparam logic [1:0] TRIM_BYTE = 2'b10;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_GNT = 2'd1,
        WAIT_RSP = 2'd2
    } mem_state_t;

endpackage

// File: rtl/store_align.sv
// rtl/store_align.sv - byte enables, lane-replicated store data and alignment check
module store_align
    import mem_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  trim,
    input  logic [31:0] rs2_data,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic        misaligned
);

    // Encoding 11 falls through to the word case on purpose.
    always_comb begin
        be         = 4'b1111;
        wdata      = rs2_data;
        misaligned = (addr_lo != 2'b00);
        case (trim)
            TRIM_BYTE: begin
                be         = 4'b0001 << addr_lo;
                wdata      = {4{rs2_data[7:0]}};
                misaligned = 1'b0;
            end
            TRIM_HALF: begin
                be         = 4'b0011 << {addr_lo[1], 1'b0};
                wdata      = {2{rs2_data[15:0]}};
                misaligned = addr_lo[0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory-access pipeline stage with req/gnt/rvalid data port and MEM/WB register
module mem_stage
    import mem_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_mem_reg_valid,
    input  logic [31:0] ex_mem_reg_alu_result,
    input  logic [31:0] ex_mem_reg_rs2_data,
    input  logic [4:0]  ex_mem_reg_rd_adr,
    input  logic        ex_mem_reg_mem_ctrl_MemRead,
    input  logic        ex_mem_reg_mem_ctrl_MemWrite,
    input  logic        ex_mem_reg_wb_ctrl_RegWrite,
    input  logic        ex_mem_reg_wb_ctrl_MemtoReg,
    input  logic        ex_mem_reg_wb_ctrl_MemSign,
    input  logic [1:0]  ex_mem_reg_wb_ctrl_MemTrim,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        mem_stage_stall,
    output logic        mem_stage_misalign,
    output logic [31:0] mem_wb_reg_alu_result,
    output logic [31:0] mem_wb_reg_data_mem_out,
    output logic [4:0]  mem_wb_reg_rd_adr,
    output logic        mem_wb_reg_wb_ctrl_RegWrite,
    output logic        mem_wb_reg_wb_ctrl_MemtoReg,
    output logic        mem_wb_reg_wb_ctrl_MemSign,
    output logic [1:0]  mem_wb_reg_wb_ctrl_MemTrim
);

    mem_state_t  state, state_next;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        misaligned;
    logic        mem_access;
    logic        mem_op;
    logic        req_c;
    logic        stall_c;
    logic        retire;
    logic        load_rsp;
    logic [31:0] load_data;

    store_align u_store_align (
        .addr_lo    (ex_mem_reg_alu_result[1:0]),
        .trim       (ex_mem_reg_wb_ctrl_MemTrim),
        .rs2_data   (ex_mem_reg_rs2_data),
        .be         (be),
        .wdata      (wdata),
        .misaligned (misaligned)
    );

    assign mem_access = ex_mem_reg_valid
                      & (ex_mem_reg_mem_ctrl_MemRead | ex_mem_reg_mem_ctrl_MemWrite);
    assign mem_op     = mem_access & ~misaligned;
    assign load_rsp   = (state == WAIT_RSP) & ex_mem_reg_mem_ctrl_MemRead;
    assign load_data  = dmem_rdata >> {ex_mem_reg_alu_result[1:0], 3'b000};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // retire = the EX/MEM instruction itself lands in MEM/WB at this edge.
    always_comb begin
        state_next = state;
        req_c      = 1'b0;
        stall_c    = 1'b0;
        retire     = 1'b0;
        case (state)
            IDLE: begin
                if (mem_op) begin
                    req_c      = 1'b1;
                    stall_c    = 1'b1;
                    state_next = dmem_gnt ? WAIT_RSP : WAIT_GNT;
                end else begin
                    retire = ex_mem_reg_valid & ~mem_access;
                end
            end
            WAIT_GNT: begin
                req_c   = 1'b1;
                stall_c = 1'b1;
                if (dmem_gnt) begin
                    state_next = WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                if (dmem_rvalid) begin
                    retire     = 1'b1;
                    state_next = IDLE;
                end else begin
                    stall_c = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Gated by rst so the port drops immediately, not at the next edge.
    assign dmem_req           = req_c & ~rst;
    assign dmem_we            = dmem_req & ex_mem_reg_mem_ctrl_MemWrite;
    assign dmem_addr          = dmem_req ? {ex_mem_reg_alu_result[31:2], 2'b00} : 32'd0;
    assign dmem_be            = dmem_req ? be : 4'd0;
    assign dmem_wdata         = dmem_req ? wdata : 32'd0;
    assign mem_stage_stall    = stall_c & ~rst;
    assign mem_stage_misalign = (state == IDLE) & mem_access & misaligned & ~rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_wb_reg_alu_result       <= 32'd0;
            mem_wb_reg_data_mem_out     <= 32'd0;
            mem_wb_reg_rd_adr           <= 5'd0;
            mem_wb_reg_wb_ctrl_RegWrite <= 1'b0;
            mem_wb_reg_wb_ctrl_MemtoReg <= 1'b0;
            mem_wb_reg_wb_ctrl_MemSign  <= 1'b0;
            mem_wb_reg_wb_ctrl_MemTrim  <= 2'd0;
        end else if (retire) begin
            mem_wb_reg_alu_result       <= ex_mem_reg_alu_result;
            mem_wb_reg_data_mem_out     <= load_rsp ? load_data : 32'd0;
            mem_wb_reg_rd_adr           <= ex_mem_reg_rd_adr;
            mem_wb_reg_wb_ctrl_RegWrite <= ex_mem_reg_wb_ctrl_RegWrite;
            mem_wb_reg_wb_ctrl_MemtoReg <= ex_mem_reg_wb_ctrl_MemtoReg;
            mem_wb_reg_wb_ctrl_MemSign  <= ex_mem_reg_wb_ctrl_MemSign;
            mem_wb_reg_wb_ctrl_MemTrim  <= ex_mem_reg_wb_ctrl_MemTrim;
        end else begin
            mem_wb_reg_alu_result       <= 32'd0;
            mem_wb_reg_data_mem_out     <= 32'd0;
            mem_wb_reg_rd_adr           <= 5'd0;
            mem_wb_reg_wb_ctrl_RegWrite <= 1'b0;
            mem_wb_reg_wb_ctrl_MemtoReg <= 1'b0;
            mem_wb_reg_wb_ctrl_MemSign  <= 1'b0;
            mem_wb_reg_wb_ctrl_MemTrim  <= 2'd0;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - self-checking bench for mem_stage with a byte-level memory model
module tb_mem_stage;

    logic        clk;
    logic        rst;
    logic        ex_mem_reg_valid;
    logic [31:0] ex_mem_reg_alu_result;
    logic [31:0] ex_mem_reg_rs2_data;
    logic [4:0]  ex_mem_reg_rd_adr;
    logic        ex_mem_reg_mem_ctrl_MemRead;
    logic        ex_mem_reg_mem_ctrl_MemWrite;
    logic        ex_mem_reg_wb_ctrl_RegWrite;
    logic        ex_mem_reg_wb_ctrl_MemtoReg;
    logic        ex_mem_reg_wb_ctrl_MemSign;
    logic [1:0]  ex_mem_reg_wb_ctrl_MemTrim;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        mem_stage_stall;
    logic        mem_stage_misalign;
    logic [31:0] mem_wb_reg_alu_result;
    logic [31:0] mem_wb_reg_data_mem_out;
    logic [4:0]  mem_wb_reg_rd_adr;
    logic        mem_wb_reg_wb_ctrl_RegWrite;
    logic        mem_wb_reg_wb_ctrl_MemtoReg;
    logic        mem_wb_reg_wb_ctrl_MemSign;
    logic [1:0]  mem_wb_reg_wb_ctrl_MemTrim;

    mem_stage dut (
        .clk                          (clk),
        .rst                          (rst),
        .ex_mem_reg_valid             (ex_mem_reg_valid),
        .ex_mem_reg_alu_result        (ex_mem_reg_alu_result),
        .ex_mem_reg_rs2_data          (ex_mem_reg_rs2_data),
        .ex_mem_reg_rd_adr            (ex_mem_reg_rd_adr),
        .ex_mem_reg_mem_ctrl_MemRead  (ex_mem_reg_mem_ctrl_MemRead),
        .ex_mem_reg_mem_ctrl_MemWrite (ex_mem_reg_mem_ctrl_MemWrite),
        .ex_mem_reg_wb_ctrl_RegWrite  (ex_mem_reg_wb_ctrl_RegWrite),
        .ex_mem_reg_wb_ctrl_MemtoReg  (ex_mem_reg_wb_ctrl_MemtoReg),
        .ex_mem_reg_wb_ctrl_MemSign   (ex_mem_reg_wb_ctrl_MemSign),
        .ex_mem_reg_wb_ctrl_MemTrim   (ex_mem_reg_wb_ctrl_MemTrim),
        .dmem_req                     (dmem_req),
        .dmem_we                      (dmem_we),
        .dmem_addr                    (dmem_addr),
        .dmem_be                      (dmem_be),
        .dmem_wdata                   (dmem_wdata),
        .dmem_gnt                     (dmem_gnt),
        .dmem_rvalid                  (dmem_rvalid),
        .dmem_rdata                   (dmem_rdata),
        .mem_stage_stall              (mem_stage_stall),
        .mem_stage_misalign           (mem_stage_misalign),
        .mem_wb_reg_alu_result        (mem_wb_reg_alu_result),
        .mem_wb_reg_data_mem_out      (mem_wb_reg_data_mem_out),
        .mem_wb_reg_rd_adr            (mem_wb_reg_rd_adr),
        .mem_wb_reg_wb_ctrl_RegWrite  (mem_wb_reg_wb_ctrl_RegWrite),
        .mem_wb_reg_wb_ctrl_MemtoReg  (mem_wb_reg_wb_ctrl_MemtoReg),
        .mem_wb_reg_wb_ctrl_MemSign   (mem_wb_reg_wb_ctrl_MemSign),
        .mem_wb_reg_wb_ctrl_MemTrim   (mem_wb_reg_wb_ctrl_MemTrim)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_bad = 0;

    // Slave memory (written from the bus) and reference memory (written from instruction semantics).
    logic [31:0] smem [int];
    logic [7:0]  rmem [int];

    // Observations from the last run_instr call.
    int          o_req, o_stall, o_mis, o_bad_bub;
    logic        o_timeout;
    logic [31:0] o_addr, o_wdata;
    logic [3:0]  o_be;
    logic        o_we;
    logic [31:0] o_wb_alu, o_wb_data;
    logic [4:0]  o_wb_rd;
    logic        o_wb_rw, o_wb_m2r, o_wb_ms;
    logic [1:0]  o_wb_trim;

    // Model expectations.
    int          e_req, e_stall, e_mis;
    logic        e_mem, e_retire;
    logic [31:0] e_addr, e_wdata, e_lane_mask, e_data;
    logic [3:0]  e_be;

    function automatic logic [31:0] init_word(input int unsigned wa);
        return (wa * 32'h9E3779B1) ^ 32'h5A5A5A5A;
    endfunction

    function automatic logic [31:0] slave_rd(input int unsigned wa);
        if (smem.exists(int'(wa))) return smem[int'(wa)];
        return init_word(wa);
    endfunction

    function automatic logic [7:0] ref_rd(input int unsigned b);
        logic [31:0] w;
        if (rmem.exists(int'(b))) return rmem[int'(b)];
        w = init_word(b >> 2);
        return w[8*(b%4) +: 8];
    endfunction

    task automatic drive(input logic v, input logic rd_en, input logic wr_en,
                         input logic [31:0] alu, input logic [31:0] rs2, input logic [4:0] rd,
                         input logic rw, input logic m2r, input logic ms, input logic [1:0] trim);
        ex_mem_reg_valid             = v;
        ex_mem_reg_mem_ctrl_MemRead  = rd_en;
        ex_mem_reg_mem_ctrl_MemWrite = wr_en;
        ex_mem_reg_alu_result        = alu;
        ex_mem_reg_rs2_data          = rs2;
        ex_mem_reg_rd_adr            = rd;
        ex_mem_reg_wb_ctrl_RegWrite  = rw;
        ex_mem_reg_wb_ctrl_MemtoReg  = m2r;
        ex_mem_reg_wb_ctrl_MemSign   = ms;
        ex_mem_reg_wb_ctrl_MemTrim   = trim;
    endtask

    // Presents the current EX/MEM contents, plays the memory slave, runs until the
    // instruction retires (first non-stall cycle). Entered and left at negedge+1.
    task automatic run_instr(input int gdly, input int rdly);
        logic in_rsp, done, is_stall;
        int   rsp_wait;
        logic [31:0] w;
        in_rsp = 0; done = 0; rsp_wait = 0;
        o_req = 0; o_stall = 0; o_mis = 0; o_bad_bub = 0; o_timeout = 0;
        o_addr = 0; o_be = 0; o_wdata = 0; o_we = 0;
        for (int cyc = 0; cyc < 64 && !done; cyc++) begin
            dmem_gnt = 0; dmem_rvalid = 0;
            #1;
            if (in_rsp) begin
                if (rsp_wait == rdly) begin
                    dmem_rvalid = 1;
                    dmem_rdata  = o_we ? $urandom : slave_rd(o_addr >> 2);
                end else begin
                    rsp_wait++;
                end
            end else if (dmem_req) begin
                if (o_req == gdly) begin
                    dmem_gnt = 1;
                    in_rsp   = 1;
                    o_addr = dmem_addr; o_be = dmem_be; o_wdata = dmem_wdata; o_we = dmem_we;
                    if (dmem_we) begin
                        w = slave_rd(dmem_addr >> 2);
                        for (int i = 0; i < 4; i++)
                            if (dmem_be[i]) w[8*i +: 8] = dmem_wdata[8*i +: 8];
                        smem[int'(dmem_addr >> 2)] = w;
                    end
                end
                o_req++;
            end
            #1;
            if (mem_stage_misalign) o_mis++;
            is_stall = mem_stage_stall;
            if (is_stall) o_stall++;
            @(posedge clk);
            #1;
            dmem_gnt = 0; dmem_rvalid = 0;
            @(negedge clk);
            #1;
            if (is_stall) begin
                if (mem_wb_reg_wb_ctrl_RegWrite !== 1'b0 || mem_wb_reg_wb_ctrl_MemtoReg !== 1'b0)
                    o_bad_bub++;
            end else begin
                o_wb_alu = mem_wb_reg_alu_result; o_wb_data = mem_wb_reg_data_mem_out;
                o_wb_rd = mem_wb_reg_rd_adr; o_wb_rw = mem_wb_reg_wb_ctrl_RegWrite;
                o_wb_m2r = mem_wb_reg_wb_ctrl_MemtoReg; o_wb_ms = mem_wb_reg_wb_ctrl_MemSign;
                o_wb_trim = mem_wb_reg_wb_ctrl_MemTrim;
                done = 1;
            end
        end
        if (!done) o_timeout = 1;
    endtask

    // Reference: what the instruction should do, from access size and address alone.
    task automatic model_instr(input int gdly, input int rdly);
        int unsigned size, a, alu;
        size = (ex_mem_reg_wb_ctrl_MemTrim == 2'b01) ? 2 : (ex_mem_reg_wb_ctrl_MemTrim == 2'b10) ? 1 : 4;
        alu  = ex_mem_reg_alu_result;
        a    = alu % 4;
        e_mem = ex_mem_reg_valid & (ex_mem_reg_mem_ctrl_MemRead | ex_mem_reg_mem_ctrl_MemWrite);
        e_mis = (e_mem && (a % size != 0)) ? 1 : 0;
        e_retire = ex_mem_reg_valid && e_mis == 0;
        e_req = 0; e_stall = 0; e_be = 0; e_wdata = 0; e_lane_mask = 0; e_data = 0;
        e_addr = alu & 32'hFFFF_FFFC;
        if (e_mem && e_mis == 0) begin
            e_req   = gdly + 1;
            e_stall = gdly + 1 + rdly;
            for (int unsigned k = 0; k < size; k++) begin
                e_be[a+k] = 1'b1;
                e_lane_mask[8*(a+k) +: 8] = 8'hFF;
                e_wdata[8*(a+k) +: 8] = ex_mem_reg_rs2_data[8*k +: 8];
            end
            if (ex_mem_reg_mem_ctrl_MemRead)
                for (int unsigned k = 0; k < 4 - a; k++) e_data[8*k +: 8] = ref_rd(alu + k);
            if (ex_mem_reg_mem_ctrl_MemWrite)
                for (int unsigned k = 0; k < size; k++) rmem[int'(alu + k)] = ex_mem_reg_rs2_data[8*k +: 8];
        end
    endtask

    task automatic test_reset;
        rst = 1; dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = 0;
        drive(1, 1, 0, 32'h100, 0, 5'd3, 1, 1, 0, 2'b00);
        repeat (2) @(negedge clk);
        #1;
        n_cmp++; if (dmem_req !== 1'b0) begin n_bad++; $display("FAIL reset_req: got %b want 0", dmem_req); end
        n_cmp++; if (mem_stage_stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall: got %b want 0", mem_stage_stall); end
        n_cmp++; if ({mem_wb_reg_alu_result, mem_wb_reg_data_mem_out, mem_wb_reg_wb_ctrl_RegWrite} !== 65'd0)
            begin n_bad++; $display("FAIL reset_memwb: got %h/%h/%b want 0", mem_wb_reg_alu_result, mem_wb_reg_data_mem_out, mem_wb_reg_wb_ctrl_RegWrite); end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00);
        rst = 0;
        @(negedge clk);
        #1;
    endtask

    task automatic test_word_load;
        smem[32'h100 >> 2] = 32'hDEADBEEF;
        drive(1, 1, 0, 32'h100, 0, 5'd5, 1, 1, 0, 2'b00);
        run_instr(0, 0);
        n_cmp++; if (o_timeout !== 1'b0) begin n_bad++; $display("FAIL word_load timeout"); end
        n_cmp++; if (o_stall !== 1) begin n_bad++; $display("FAIL word_load_stall: got %0d want 1", o_stall); end
        n_cmp++; if (o_wb_data !== 32'hDEADBEEF) begin n_bad++; $display("FAIL word_load_data: got %h want deadbeef", o_wb_data); end
        n_cmp++; if (o_wb_rw !== 1'b1 || o_wb_rd !== 5'd5) begin n_bad++; $display("FAIL word_load_wb: got rw=%b rd=%0d want 1/5", o_wb_rw, o_wb_rd); end
    endtask

    task automatic test_byte_store;
        drive(1, 0, 1, 32'h103, 32'h000000A5, 5'd0, 0, 0, 0, 2'b10);
        run_instr(0, 0);
        n_cmp++; if (o_be !== 4'b1000) begin n_bad++; $display("FAIL byte_store_be: got %b want 1000", o_be); end
        n_cmp++; if (o_wdata !== 32'hA5A5A5A5) begin n_bad++; $display("FAIL byte_store_wdata: got %h want a5a5a5a5", o_wdata); end
        n_cmp++; if (o_addr !== 32'h100 || o_we !== 1'b1) begin n_bad++; $display("FAIL byte_store_addr: got %h we=%b want 100/1", o_addr, o_we); end
    endtask

    task automatic test_half_load_delayed;
        smem[32'h200 >> 2] = 32'h8001_1234;
        drive(1, 1, 0, 32'h202, 0, 5'd9, 1, 1, 1, 2'b01);
        run_instr(2, 1);
        n_cmp++; if (o_req !== 3) begin n_bad++; $display("FAIL half_delay_req: got %0d want 3", o_req); end
        n_cmp++; if (o_stall !== 4) begin n_bad++; $display("FAIL half_delay_stall: got %0d want 4", o_stall); end
        n_cmp++; if (o_bad_bub !== 0) begin n_bad++; $display("FAIL half_delay_bubbles: got %0d non-bubbles want 0", o_bad_bub); end
        n_cmp++; if (o_wb_data !== 32'h0000_8001 || o_wb_rw !== 1'b1) begin n_bad++; $display("FAIL half_delay_data: got %h rw=%b want 00008001/1", o_wb_data, o_wb_rw); end
    endtask

    task automatic test_misaligned;
        drive(1, 1, 0, 32'h101, 0, 5'd7, 1, 1, 0, 2'b00);
        run_instr(0, 0);
        n_cmp++; if (o_req !== 0) begin n_bad++; $display("FAIL misalign_req: got %0d want 0", o_req); end
        n_cmp++; if (o_mis !== 1) begin n_bad++; $display("FAIL misalign_pulse: got %0d cycles want 1", o_mis); end
        n_cmp++; if (o_wb_rw !== 1'b0 || o_stall !== 0) begin n_bad++; $display("FAIL misalign_wb: got rw=%b stall=%0d want 0/0", o_wb_rw, o_stall); end
    endtask

    task automatic test_reset_in_wait_rsp;
        drive(1, 1, 0, 32'h100, 0, 5'd4, 1, 1, 0, 2'b00);
        #1;
        dmem_gnt = dmem_req;
        @(posedge clk);
        #1;
        dmem_gnt = 0;
        @(negedge clk);
        rst = 1;
        #1;
        n_cmp++; if (dmem_req !== 1'b0 || mem_stage_stall !== 1'b0) begin n_bad++; $display("FAIL rst_rsp_outputs: got req=%b stall=%b want 0/0", dmem_req, mem_stage_stall); end
        n_cmp++; if (mem_wb_reg_wb_ctrl_RegWrite !== 1'b0 || mem_wb_reg_data_mem_out !== 32'd0) begin n_bad++; $display("FAIL rst_rsp_memwb: got rw=%b data=%h want 0/0", mem_wb_reg_wb_ctrl_RegWrite, mem_wb_reg_data_mem_out); end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00);
        @(negedge clk);
        rst = 0;
        #1;
        dmem_rvalid = 1; dmem_rdata = 32'hCAFEF00D;
        #1;
        n_cmp++; if (mem_stage_stall !== 1'b0 || dmem_req !== 1'b0) begin n_bad++; $display("FAIL rst_rsp_late_rvalid: got stall=%b req=%b want 0/0", mem_stage_stall, dmem_req); end
        @(posedge clk);
        #1;
        dmem_rvalid = 0;
        @(negedge clk);
        #1;
        n_cmp++; if (mem_wb_reg_wb_ctrl_RegWrite !== 1'b0 || mem_wb_reg_data_mem_out !== 32'd0) begin n_bad++; $display("FAIL rst_rsp_ignored: got rw=%b data=%h want 0/0", mem_wb_reg_wb_ctrl_RegWrite, mem_wb_reg_data_mem_out); end
        drive(1, 0, 0, 32'h1234_5678, 0, 5'd12, 1, 0, 0, 2'b00);
        run_instr(0, 0);
        n_cmp++; if (o_stall !== 0 || o_wb_alu !== 32'h1234_5678 || o_wb_rw !== 1'b1 || o_wb_data !== 32'd0)
            begin n_bad++; $display("FAIL alu_pass: got stall=%0d alu=%h rw=%b data=%h want 0/12345678/1/0", o_stall, o_wb_alu, o_wb_rw, o_wb_data); end
    endtask

    task automatic test_random(input int n);
        int unsigned t, size, off;
        int gd, rd;
        logic [1:0] trim;
        for (int i = 0; i < n; i++) begin
            t    = $urandom_range(0, 9);
            trim = 2'($urandom_range(0, 3));
            size = (trim == 2'b01) ? 2 : (trim == 2'b10) ? 1 : 4;
            off  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : size * $urandom_range(0, 4 / size - 1);
            gd   = $urandom_range(0, 3);
            rd   = $urandom_range(0, 3);
            if (t <= 3)
                drive(1, 1, 0, 32'h300 + ($urandom_range(0, 15) << 2) + off, $urandom, 5'($urandom), 1, 1, 1'($urandom), trim);
            else if (t <= 6)
                drive(1, 0, 1, 32'h300 + ($urandom_range(0, 15) << 2) + off, $urandom, 5'($urandom), 1'($urandom), 0, 0, trim);
            else if (t <= 8)
                drive(1, 0, 0, $urandom, $urandom, 5'($urandom), 1, 0, 0, trim);
            else
                drive(0, 1'($urandom), 0, $urandom, $urandom, 5'($urandom), 1, 1, 0, trim);
            model_instr(gd, rd);
            run_instr(gd, rd);
            n_cmp++; if (o_timeout !== 1'b0) begin n_bad++; $display("FAIL rnd%0d timeout", i); end
            n_cmp++; if (o_req !== e_req || o_stall !== e_stall || o_mis !== e_mis || o_bad_bub !== 0)
                begin n_bad++; $display("FAIL rnd%0d timing: got req=%0d stall=%0d mis=%0d badbub=%0d want %0d/%0d/%0d/0", i, o_req, o_stall, o_mis, o_bad_bub, e_req, e_stall, e_mis); end
            if (e_req != 0) begin
                n_cmp++; if (o_addr !== e_addr || o_be !== e_be || o_we !== ex_mem_reg_mem_ctrl_MemWrite || (o_wdata & e_lane_mask) !== e_wdata)
                    begin n_bad++; $display("FAIL rnd%0d bus: got addr=%h be=%b we=%b wd=%h want %h/%b/%b/%h", i, o_addr, o_be, o_we, o_wdata & e_lane_mask, e_addr, e_be, ex_mem_reg_mem_ctrl_MemWrite, e_wdata); end
            end
            if (e_retire) begin
                n_cmp++; if (o_wb_alu !== ex_mem_reg_alu_result || o_wb_rd !== ex_mem_reg_rd_adr || o_wb_data !== e_data
                             || o_wb_rw !== ex_mem_reg_wb_ctrl_RegWrite || o_wb_m2r !== ex_mem_reg_wb_ctrl_MemtoReg
                             || o_wb_ms !== ex_mem_reg_wb_ctrl_MemSign || o_wb_trim !== trim)
                    begin n_bad++; $display("FAIL rnd%0d memwb: got alu=%h rd=%0d data=%h rw=%b want %h/%0d/%h/%b", i, o_wb_alu, o_wb_rd, o_wb_data, o_wb_rw, ex_mem_reg_alu_result, ex_mem_reg_rd_adr, e_data, ex_mem_reg_wb_ctrl_RegWrite); end
            end else begin
                n_cmp++; if (o_wb_rw !== 1'b0 || o_wb_m2r !== 1'b0)
                    begin n_bad++; $display("FAIL rnd%0d bubble: got rw=%b m2r=%b want 0/0", i, o_wb_rw, o_wb_m2r); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_word_load();
        test_byte_store();
        test_half_load_delayed();
        test_misaligned();
        test_reset_in_wait_rsp();
        test_random(120);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
